addn_sub_seq_v: RTL
===================

# addn_sub_seq_v

Parametrised, multi-cycle adder/subtractor. It processes an N-bit operand pair CHUNK bits per clock through a registered carry chain, which trades latency for a narrow adder datapath. It is the clocked successor of the team's fixed 16-bit combinational add/sub. It sits behind a start/done handshake in the datapath or ALU wrapper and keeps the same mode and carry/borrow conventions: `i_ADDN_SUB`=1 subtracts, and `o_C`=1 means borrow.

## Interface
Parameters:
- `WIDTH`, default 16: operand and result width in bits. Must be ≥2.
- `CHUNK`, default 4: bits added per clock. Must divide `WIDTH`. `CHUNK`=`WIDTH` gives single-pass operation.

Ports (clock and reset first):
- `i_CLK`, in, 1: the single clock. All state updates on the rising edge.
- `i_RSTn`, in, 1: asynchronous, active-low reset.
- `i_START`, in, 1: request. Sampled only in IDLE.
- `i_A`, in, `WIDTH`: operand A. Captured on an accepted start.
- `i_B`, in, `WIDTH`: operand B. Captured on an accepted start.
- `i_ADDN_SUB`, in, 1: mode. 0 = A+B, 1 = A−B. Captured on an accepted start.
- `o_BUSY`, out, 1: high in RUN and DONE.
- `o_DONE`, out, 1: one-cycle pulse when the result is valid.
- `o_S`, out, `WIDTH`: result.
- `o_C`, out, 1: carry out (add) or borrow (subtract).
- `o_V`, out, 1: signed overflow (see Configuration).

## Operation
- States: IDLE, RUN, DONE. `NCH` = `WIDTH`/`CHUNK`.
- **IDLE**
  - `i_START`=1 latches A into `rA`.
  - Latches B XOR {`WIDTH`{`i_ADDN_SUB`}} into `rB`.
  - Latches mode into `rM`.
  - Sets carry `rc` = `i_ADDN_SUB` and chunk index `k`=0, then goes to RUN.
  - `i_START`=0 stays in IDLE.
- **RUN**, once per cycle:
  - {c', s} = `rA`[k] + `rB`[k] + `rc`, where [k] is bits k·CHUNK+CHUNK−1 .. k·CHUNK.
  - s is written into internal accumulator slice k, `rc` ← c', and k increments.
  - On the cycle where k = `NCH`−1, go to DONE and load the outputs:
    - `o_S` ← accumulator with the final slice merged.
    - `o_C` ← c' XOR `rM`.
    - `o_V` ← carry into bit `WIDTH`−1 XOR carry out of bit `WIDTH`−1.
- **DONE**: `o_DONE`=1 for exactly one cycle, then unconditionally go to IDLE.
- `i_START` outside IDLE (RUN or DONE) is ignored. It is not queued.
- `i_A`, `i_B` and `i_ADDN_SUB` may change freely after acceptance.
- `o_S`, `o_C` and `o_V` change only on entry to DONE. They hold their value until the next DONE, including through IDLE and RUN.
- Arithmetic is modulo 2^`WIDTH`. There is no saturation.
- Subtract is A + ~B + 1, so `o_C`=1 exactly when unsigned A < B.

## Timing
- Start accepted at edge t. RUN occupies edges t+1 .. t+`NCH`.
- DONE state and `o_DONE`=1 are registered at edge t+`NCH`. DONE is left at edge t+`NCH`+1.
- Start-to-done latency is `NCH` cycles. Throughput is one operation per `NCH`+2 cycles (IDLE re-entry required).
- For `CHUNK`=`WIDTH`: RUN lasts one cycle, and `o_DONE` is high one cycle after acceptance.
- Reset (`i_RSTn`=0, any time, including mid-RUN or during DONE):
  - State → IDLE immediately, and the operation in flight is discarded.
  - `o_BUSY`, `o_DONE`, `o_S`, `o_C` and `o_V` all reset to 0, as do all internal registers.
  - The first start can be accepted on the first edge after `i_RSTn` deasserts.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- Macro `ADDN_SUB_OVF_EN`.
- **Defined**: the MSB carry-in is tracked in the final chunk, and `o_V` is computed as described in Operation.
- **Undefined**: the overflow logic is omitted and `o_V` is tied to 0. The port remains, so the port list is unchanged.
- `o_S`, `o_C` and timing are identical either way.

## Test plan
All scenarios use `WIDTH`=16, `CHUNK`=4 unless stated otherwise.
1. Add: A=0x1234, B=0x0FED, mode 0 → `o_DONE` 4 cycles after start, `o_S`=0x2221, `o_C`=0, `o_V`=0. `o_BUSY` is high for 5 cycles.
2. Subtract with borrow: A=0x0005, B=0x0007, mode 1 → `o_S`=0xFFFE, `o_C`=1, `o_V`=0.
3. Overflow:
   - With `ADDN_SUB_OVF_EN`: 0x7FFF+0x0001 → `o_S`=0x8000, `o_C`=0, `o_V`=1. 0x8000−0x0001 → 0x7FFF, `o_V`=1.
   - Without the macro: `o_V`=0 for both.
4. Busy rejection:
   - Hold `i_START`=1 continuously with 0xFFFF+0x0001 → exactly one `o_DONE` per 6 cycles, `o_S`=0x0000, `o_C`=1.
   - Changing `i_A` mid-RUN does not alter the result.
5. Reset mid-operation: assert `i_RSTn`=0 at RUN cycle 2 → all outputs 0 and state IDLE at once. A new start after release completes normally.
6. `WIDTH`=32, `CHUNK`=32: A=0xFFFFFFFF, B=0x00000001, mode 0 → `o_DONE` 1 cycle after start, `o_S`=0, `o_C`=1.

Source files
------------

// File: rtl/addn_sub_seq_v.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock through a registered carry chain.
// Define ADDN_SUB_OVF_EN to compute signed overflow on o_V (otherwise o_V is tied to 0).
module addn_sub_seq_v #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
    input  logic             i_START,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_ADDN_SUB,
    output logic             o_BUSY,
    output logic             o_DONE,
    output logic [WIDTH-1:0] o_S,
    output logic             o_C,
    output logic             o_V
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NPAD = 2 ** KW;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             m_q, m_d;
    logic             c_q, c_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             v_q, v_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CHUNK-1:0] a_ch [NPAD];
    logic [CHUNK-1:0] b_ch [NPAD];
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] acc_merge;

    // Padded chunk tables keep the selector a plain array index for any NCH.
    for (genvar gi = 0; gi < NPAD; gi++) begin : g_chunk
        if (gi < NCH) begin : g_real
            assign a_ch[gi] = a_q[gi*CHUNK +: CHUNK];
            assign b_ch[gi] = b_q[gi*CHUNK +: CHUNK];
            assign acc_merge[gi*CHUNK +: CHUNK] =
                (k_q == KW'(gi)) ? sum[CHUNK-1:0] : acc_q[gi*CHUNK +: CHUNK];
        end else begin : g_pad
            assign a_ch[gi] = '0;
            assign b_ch[gi] = '0;
        end
    end

    assign a_slice = a_ch[k_q];
    assign b_slice = b_ch[k_q];
    assign sum     = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, c_q};

`ifdef ADDN_SUB_OVF_EN
    logic msb_cin;
    // Carry into the MSB recovered from the MSB sum bit and its operands.
    assign msb_cin = sum[CHUNK-1] ^ a_slice[CHUNK-1] ^ b_slice[CHUNK-1];
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        c_d     = c_q;
        k_d     = k_q;
        acc_d   = acc_q;
        s_d     = s_q;
        co_d    = co_q;
        v_d     = v_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (i_START) begin
                    a_d     = i_A;
                    b_d     = i_B ^ {WIDTH{i_ADDN_SUB}};
                    m_d     = i_ADDN_SUB;
                    c_d     = i_ADDN_SUB;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_merge;
                c_d   = sum[CHUNK];
                k_d   = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    s_d     = acc_merge;
                    co_d    = sum[CHUNK] ^ m_q;
`ifdef ADDN_SUB_OVF_EN
                    v_d     = msb_cin ^ sum[CHUNK];
`else
                    v_d     = 1'b0;
`endif
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= 1'b0;
            c_q     <= 1'b0;
            k_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            c_q     <= c_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            co_q    <= co_d;
            v_q     <= v_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_BUSY = busy_q;
    assign o_DONE = done_q;
    assign o_S    = s_q;
    assign o_C    = co_q;
    assign o_V    = v_q;
endmodule
